mold_retrans_req: RTL and testbench

//  Downstream of the missed-message detector. Queues missing sequence-number ranges
//  (sid, start, count) and serialises each as a MoldUDP64 retransmission request
//  (10B session, 8B seq num, 2B msg count = 20B, big-endian) on a 64-bit valid/ready

---
 rtl/mold_retrans_req_if.sv | 24 ++
 rtl/mold_retrans_req.sv | 192 +++++++++++++++++++
 tb/tb_mold_retrans_req.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mold_retrans_req_if.sv
// Purpose : 64-bit valid/ready byte stream carrying MoldUDP64 retransmission requests.
// Latency : n/a (signal bundle only).
// Backpressure: req_ready_i from the sink stalls the source; beat held while stalled.
// Ports (master = request generator):
//   req_v_o     beat valid             req_ready_i  sink accepts beat
//   req_data_o  beat data, byte 0 LSB  req_keep_o   byte enables
//   req_last_o  final beat of packet
interface mold_retrans_req_if;
  logic        req_v_o;
  logic        req_ready_i;
  logic [63:0] req_data_o;
  logic [7:0]  req_keep_o;
  logic        req_last_o;

  modport master (
    output req_v_o, req_data_o, req_keep_o, req_last_o,
    input  req_ready_i
  );

  modport slave (
    input  req_v_o, req_data_o, req_keep_o, req_last_o,
    output req_ready_i
  );
endinterface

// File: rtl/mold_retrans_req.sv
// Purpose : queue missing seq ranges and emit each as 20B MoldUDP64 retrans requests.
// Latency : miss pushed in cycle N -> first beat valid in N+2; requests back-to-back.
// Backpressure: beats stall on req_ready_i; upstream has none, full queue drops + flags.
// Ports:
//   clk, nreset               clock, async active-low reset
//   miss_v_i/sid/start/cnt    miss range input (cnt==0 ignored)
//   req (master modport)      3-beat request packet stream
//   fifo_full_o               queue holds FIFO_DEPTH entries
//   overflow_o                sticky, a range was dropped on a full queue
module mold_retrans_req #(
  parameter int unsigned           SEQ_NUM_W   = 64,
  parameter int unsigned           SID_W       = 80,
  parameter int unsigned           ML_W        = 16,
  parameter logic [ML_W-1:0]       MAX_REQ_CNT = 16'hFFFF,
  parameter int unsigned           FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 miss_v_i,
  input  logic [SID_W-1:0]     miss_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
  mold_retrans_req_if.master   req,
  output logic                 fifo_full_o,
  output logic                 overflow_o
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned PKT_W = SID_W + SEQ_NUM_W + ML_W;
  localparam int unsigned PAD_W = 192;  // three 64-bit beats

  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_B2} state_t;

  // ---------------- miss-range queue ----------------
  logic [SID_W-1:0]     r_q_sid   [FIFO_DEPTH];
  logic [SEQ_NUM_W-1:0] r_q_start [FIFO_DEPTH];
  logic [SEQ_NUM_W-1:0] r_q_cnt   [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  logic w_full, w_empty, w_push, w_pop;
  logic [SID_W-1:0]     w_head_sid;
  logic [SEQ_NUM_W-1:0] w_head_start, w_head_cnt;

  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  // Full is judged on the registered count, so a same-cycle pop cannot save a push.
  assign w_push       = miss_v_i & (miss_cnt_i != '0) & ~w_full;
  assign w_head_sid   = r_q_sid[r_rp];
  assign w_head_start = r_q_start[r_rp];
  assign w_head_cnt   = r_q_cnt[r_rp];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_sid[r_wp]   <= miss_sid_i;
      r_q_start[r_wp] <= miss_start_i;
      r_q_cnt[r_wp]   <= miss_cnt_i;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (~w_push & w_pop) r_count <= r_count - 1'b1;
      if (miss_v_i & (miss_cnt_i != '0) & w_full) r_overflow <= 1'b1;
    end
  end

  // ---------------- request serialiser ----------------
  state_t               r_state;
  logic [SID_W-1:0]     r_sid;
  logic [SEQ_NUM_W-1:0] r_seq, r_rem;
  logic [ML_W-1:0]      r_cnt;
  logic                 r_req_v, r_req_last;
  logic [63:0]          r_req_data;
  logic [7:0]           r_req_keep;

  logic                 w_accept;
  logic [SEQ_NUM_W-1:0] w_seq_adv, w_rem_left;
  logic [ML_W-1:0]      w_head_req, w_rem_req;

  function automatic logic [ML_W-1:0] f_min(input logic [SEQ_NUM_W-1:0] v);
    return (v > SEQ_NUM_W'(MAX_REQ_CNT)) ? MAX_REQ_CNT : v[ML_W-1:0];
  endfunction

  // Beat b carries packet bytes 8b..8b+7; packet byte 0 is the sid MSB and lands
  // in data[7:0]. Zero padding past byte 19 fills the unused half of the last beat.
  function automatic logic [63:0] f_beat(input logic [1:0] b,
                                         input logic [SID_W-1:0] sid,
                                         input logic [SEQ_NUM_W-1:0] seq,
                                         input logic [ML_W-1:0] cnt);
    logic [PAD_W-1:0] pkt;
    logic [63:0]      d;
    pkt = {sid, seq, cnt, {(PAD_W-PKT_W){1'b0}}};
    for (int i = 0; i < 8; i++)
      d[8*i +: 8] = pkt[PAD_W-1-8*(int'(b)*8+i) -: 8];
    return d;
  endfunction

  assign w_accept   = r_req_v & req.req_ready_i;
  assign w_seq_adv  = r_seq + SEQ_NUM_W'(r_cnt);   // wraps modulo 2^SEQ_NUM_W
  assign w_rem_left = r_rem - SEQ_NUM_W'(r_cnt);
  assign w_head_req = f_min(w_head_cnt);
  assign w_rem_req  = f_min(w_rem_left);
  assign w_pop      = ~w_empty & ((r_state == S_IDLE) |
                      ((r_state == S_B2) & w_accept & (w_rem_left == '0)));

  // Outputs are loaded together with the state they belong to, so the beat
  // presented in a state is stable for as long as the state is held.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_sid      <= '0;
      r_seq      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_req_v    <= 1'b0;
      r_req_data <= '0;
      r_req_keep <= '0;
      r_req_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_state    <= S_B0;
          r_sid      <= w_head_sid;
          r_seq      <= w_head_start;
          r_rem      <= w_head_cnt;
          r_cnt      <= w_head_req;
          r_req_v    <= 1'b1;
          r_req_data <= f_beat(2'd0, w_head_sid, w_head_start, w_head_req);
          r_req_keep <= 8'hFF;
          r_req_last <= 1'b0;
        end
        S_B0: if (w_accept) begin
          r_state    <= S_B1;
          r_req_data <= f_beat(2'd1, r_sid, r_seq, r_cnt);
        end
        S_B1: if (w_accept) begin
          r_state    <= S_B2;
          r_req_data <= f_beat(2'd2, r_sid, r_seq, r_cnt);
          r_req_keep <= 8'h0F;
          r_req_last <= 1'b1;
        end
        S_B2: if (w_accept) begin
          if (w_rem_left != '0) begin
            // Continue the same range with the next chunk, no idle cycle.
            r_state    <= S_B0;
            r_seq      <= w_seq_adv;
            r_rem      <= w_rem_left;
            r_cnt      <= w_rem_req;
            r_req_data <= f_beat(2'd0, r_sid, w_seq_adv, w_rem_req);
            r_req_keep <= 8'hFF;
            r_req_last <= 1'b0;
          end else if (!w_empty) begin
            r_state    <= S_B0;
            r_sid      <= w_head_sid;
            r_seq      <= w_head_start;
            r_rem      <= w_head_cnt;
            r_cnt      <= w_head_req;
            r_req_data <= f_beat(2'd0, w_head_sid, w_head_start, w_head_req);
            r_req_keep <= 8'hFF;
            r_req_last <= 1'b0;
          end else begin
            r_state    <= S_IDLE;
            r_req_v    <= 1'b0;
            r_req_data <= '0;
            r_req_keep <= '0;
            r_req_last <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req.req_v_o    = r_req_v;
  assign req.req_data_o = r_req_data;
  assign req.req_keep_o = r_req_keep;
  assign req.req_last_o = r_req_last;
  assign fifo_full_o    = w_full;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_mold_retrans_req.sv
// Purpose : directed self-checking bench for mold_retrans_req.
// Latency : expects first beat two cycles after a push into an idle block.
// Backpressure: drives req_ready_i low in chosen windows to stall the stream.
module tb_mold_retrans_req;
  logic        clk = 1'b0;
  logic        nreset;
  logic        miss_v;
  logic [79:0] miss_sid;
  logic [63:0] miss_start, miss_cnt;
  logic        fifo_full, overflow;
  int          checks = 0;
  int          failures = 0;

  mold_retrans_req_if req_if();

  mold_retrans_req dut (
    .clk          (clk),
    .nreset       (nreset),
    .miss_v_i     (miss_v),
    .miss_sid_i   (miss_sid),
    .miss_start_i (miss_start),
    .miss_cnt_i   (miss_cnt),
    .req          (req_if),
    .fifo_full_o  (fifo_full),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] EXP_KEEP = 24'h0F_FF_FF;
  localparam logic [2:0]  EXP_LAST = 3'b100;

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = x[63-8*i -: 8];
    return r;
  endfunction

  // Expected 3 beats {b2,b1,b0} of one request packet.
  function automatic logic [191:0] exp_pkt(input logic [79:0] sid, input logic [63:0] seq,
                                           input logic [15:0] cnt);
    logic [63:0] b0, b1, b2;
    b0 = bswap64(sid[79:16]);
    b1 = bswap64({sid[15:0], seq[63:16]});
    b2 = bswap64({seq[15:0], cnt, 32'h0});
    return {b2, b1, b0};
  endfunction

  task automatic push(input logic [79:0] sid, input logic [63:0] st, input logic [63:0] cnt);
    miss_v = 1'b1; miss_sid = sid; miss_start = st; miss_cnt = cnt;
    @(negedge clk);
    miss_v = 1'b0;
  endtask

  // Called at a negedge; raises ready and takes the next valid beat.
  task automatic get_beat(output logic [63:0] d, output logic [7:0] k, output logic l,
                          output bit ok, output int w);
    req_if.req_ready_i = 1'b1;
    ok = 1'b0; w = 0; d = '0; k = '0; l = 1'b0;
    while (!ok && w < 20) begin
      if (req_if.req_v_o) begin
        d = req_if.req_data_o; k = req_if.req_keep_o; l = req_if.req_last_o; ok = 1'b1;
      end else begin
        w++;
      end
      @(negedge clk);
    end
  endtask

  task automatic get_pkt(output logic [191:0] d, output logic [23:0] k, output logic [2:0] l,
                         output bit ok, output int w_first, output int w_rest);
    logic [63:0] bd; logic [7:0] bk; logic bl; bit bok; int bw;
    ok = 1'b1; w_first = 0; w_rest = 0;
    for (int b = 0; b < 3; b++) begin
      get_beat(bd, bk, bl, bok, bw);
      d[64*b +: 64] = bd; k[8*b +: 8] = bk; l[b] = bl; ok &= bok;
      if (b == 0) w_first = bw; else w_rest += bw;
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0; miss_v = 1'b0; miss_sid = '0; miss_start = '0; miss_cnt = '0;
    req_if.req_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_if.req_v_o, req_if.req_data_o, req_if.req_keep_o, req_if.req_last_o,
         fifo_full, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs v=%b data=%h keep=%h last=%b full=%b ovf=%b, all must be 0",
               req_if.req_v_o, req_if.req_data_o, req_if.req_keep_o, req_if.req_last_o,
               fifo_full, overflow);
    end
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_if.req_v_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle v=%b exp 0", req_if.req_v_o);
    end
  endtask

  task automatic test_single;
    logic [191:0] d; logic [23:0] k; logic [2:0] l; bit ok; int wf, wr;
    push(80'h1, 64'h10, 64'd3);
    get_pkt(d, k, l, ok, wf, wr);
    checks++;
    if (!ok || wf !== 1 || wr !== 0) begin
      failures++; $display("FAIL t1_timing ok=%b first_wait=%0d rest_wait=%0d exp 1/1/0", ok, wf, wr);
    end
    checks++;
    if (d !== {64'h0000_0000_0300_1000, 64'h0000_0000_0000_0100, 64'h0}) begin
      failures++; $display("FAIL t1_data got=%h exp=%h", d,
                           {64'h0000_0000_0300_1000, 64'h0000_0000_0000_0100, 64'h0});
    end
    checks++;
    if (k !== EXP_KEEP || l !== EXP_LAST) begin
      failures++; $display("FAIL t1_keep_last keep=%h last=%b exp %h %b", k, l, EXP_KEEP, EXP_LAST);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_if.req_v_o !== 1'b0) begin
      failures++; $display("FAIL t1_idle v=%b exp 0", req_if.req_v_o);
    end
  endtask

  task automatic test_split;
    logic [191:0] d1, d2; logic [23:0] k1, k2; logic [2:0] l1, l2; bit ok1, ok2; int wf1, wr1, wf2, wr2;
    logic [79:0] sid;
    sid = 80'h0102_0304_0506_0708_090A;
    push(sid, 64'h10, 64'h1_0001);
    get_pkt(d1, k1, l1, ok1, wf1, wr1);
    get_pkt(d2, k2, l2, ok2, wf2, wr2);
    checks++;
    if (!ok1 || d1 !== exp_pkt(sid, 64'h10, 16'hFFFF)) begin
      failures++; $display("FAIL t2_pkt1 ok=%b got=%h exp=%h", ok1, d1, exp_pkt(sid, 64'h10, 16'hFFFF));
    end
    checks++;
    if (!ok2 || d2 !== exp_pkt(sid, 64'h1000F, 16'h0002)) begin
      failures++; $display("FAIL t2_pkt2 ok=%b got=%h exp=%h", ok2, d2, exp_pkt(sid, 64'h1000F, 16'h0002));
    end
    checks++;
    if (wf2 !== 0 || wr1 !== 0 || wr2 !== 0 || k2 !== EXP_KEEP || l2 !== EXP_LAST) begin
      failures++; $display("FAIL t2_back_to_back gap=%0d/%0d/%0d keep=%h last=%b exp 0/0/0 %h %b",
                           wf2, wr1, wr2, k2, l2, EXP_KEEP, EXP_LAST);
    end
  endtask

  task automatic test_wrap;
    logic [191:0] d1, d2; logic [23:0] k; logic [2:0] l; bit ok1, ok2; int wf, wr;
    logic [79:0] sid;
    sid = 80'hDEAD_BEEF_0000_1111_2222;
    push(sid, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0001);
    get_pkt(d1, k, l, ok1, wf, wr);
    get_pkt(d2, k, l, ok2, wf, wr);
    checks++;
    if (!ok1 || d1 !== exp_pkt(sid, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF)) begin
      failures++; $display("FAIL t3_pkt1 ok=%b got=%h exp=%h", ok1, d1,
                           exp_pkt(sid, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF));
    end
    checks++;
    if (!ok2 || d2 !== exp_pkt(sid, 64'hFFFE, 16'h0002)) begin
      failures++; $display("FAIL t3_wrap ok=%b got=%h exp=%h", ok2, d2, exp_pkt(sid, 64'hFFFE, 16'h0002));
    end
  endtask

  task automatic test_stall;
    logic [63:0] bd; logic [7:0] bk; logic bl; bit ok; int w;
    logic [191:0] e; int bad;
    logic [79:0] sid;
    sid = 80'h1122_3344_5566_7788_99AA;
    e = exp_pkt(sid, 64'h0123_4567_89AB_CDEF, 16'h0007);
    push(sid, 64'h0123_4567_89AB_CDEF, 64'd7);
    get_beat(bd, bk, bl, ok, w);
    checks++;
    if (!ok || bd !== e[63:0]) begin
      failures++; $display("FAIL t4_b0 ok=%b got=%h exp=%h", ok, bd, e[63:0]);
    end
    req_if.req_ready_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (req_if.req_v_o !== 1'b1 || req_if.req_data_o !== e[127:64] ||
          req_if.req_keep_o !== 8'hFF || req_if.req_last_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL t4_hold bad_cycles=%0d exp 0 (data now %h exp %h)",
                           bad, req_if.req_data_o, e[127:64]);
    end
    get_beat(bd, bk, bl, ok, w);
    checks++;
    if (!ok || w !== 0 || bd !== e[127:64] || bk !== 8'hFF || bl !== 1'b0) begin
      failures++; $display("FAIL t4_b1 ok=%b wait=%0d got=%h exp=%h", ok, w, bd, e[127:64]);
    end
    get_beat(bd, bk, bl, ok, w);
    checks++;
    if (!ok || w !== 0 || bd !== e[191:128] || bk !== 8'h0F || bl !== 1'b1) begin
      failures++; $display("FAIL t4_b2 ok=%b wait=%0d got=%h keep=%h last=%b exp=%h 0f 1",
                           ok, w, bd, bk, bl, e[191:128]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_if.req_v_o !== 1'b0) begin
      failures++; $display("FAIL t4_no_dup v=%b exp 0", req_if.req_v_o);
    end
  endtask

  task automatic test_overflow;
    logic [191:0] d; logic [23:0] k; logic [2:0] l; bit ok; int wf, wr; bit any_v;
    req_if.req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(80'h50 + 80'(i), 64'h1000 * 64'(i), 64'(i + 1));
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL t5_full full=%b ovf=%b exp 1 0", fifo_full, overflow);
    end
    push(80'h99, 64'h9999, 64'd9);
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b1) begin
      failures++; $display("FAIL t5_overflow ovf=%b full=%b exp 1 1", overflow, fifo_full);
    end
    for (int i = 0; i < 5; i++) begin
      get_pkt(d, k, l, ok, wf, wr);
      checks++;
      if (!ok || d !== exp_pkt(80'h50 + 80'(i), 64'h1000 * 64'(i), 16'(i + 1)) ||
          k !== EXP_KEEP || l !== EXP_LAST) begin
        failures++; $display("FAIL t5_pkt%0d ok=%b got=%h exp=%h", i, ok, d,
                             exp_pkt(80'h50 + 80'(i), 64'h1000 * 64'(i), 16'(i + 1)));
      end
    end
    any_v = 1'b0;
    repeat (8) begin any_v |= req_if.req_v_o; @(negedge clk); end
    checks++;
    if (any_v !== 1'b0 || fifo_full !== 1'b0) begin
      failures++; $display("FAIL t5_dropped extra_beat=%b full=%b exp 0 0", any_v, fifo_full);
    end
    push(80'h77, 64'h7777, 64'd0);
    any_v = 1'b0;
    repeat (6) begin any_v |= req_if.req_v_o; @(negedge clk); end
    checks++;
    if (any_v !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL t5_cnt0 beat=%b ovf=%b exp 0 1", any_v, overflow);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] bd; logic [7:0] bk; logic bl; bit ok; int w; bit any_v;
    logic [191:0] d, ea; logic [23:0] k; logic [2:0] l; int wf, wr;
    ea = exp_pkt(80'hA, 64'h100, 16'd1);
    req_if.req_ready_i = 1'b0;
    push(80'hA, 64'h100, 64'd1);
    push(80'hB, 64'h200, 64'd1);
    get_beat(bd, bk, bl, ok, w);
    req_if.req_ready_i = 1'b0;
    checks++;
    if (req_if.req_v_o !== 1'b1 || req_if.req_data_o !== ea[127:64]) begin
      failures++; $display("FAIL t6_in_b1 v=%b data=%h exp 1 %h", req_if.req_v_o,
                           req_if.req_data_o, ea[127:64]);
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({req_if.req_v_o, req_if.req_data_o, req_if.req_keep_o, req_if.req_last_o,
         fifo_full, overflow} !== '0) begin
      failures++; $display("FAIL t6_async v=%b data=%h keep=%h last=%b full=%b ovf=%b, all must be 0",
                           req_if.req_v_o, req_if.req_data_o, req_if.req_keep_o,
                           req_if.req_last_o, fifo_full, overflow);
    end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    req_if.req_ready_i = 1'b1;
    any_v = 1'b0;
    repeat (5) begin @(negedge clk); any_v |= req_if.req_v_o; end
    checks++;
    if (any_v !== 1'b0) begin
      failures++; $display("FAIL t6_queue_flushed beat=%b exp 0", any_v);
    end
    push(80'hC, 64'h300, 64'd2);
    get_pkt(d, k, l, ok, wf, wr);
    checks++;
    if (!ok || wf !== 1 || d !== exp_pkt(80'hC, 64'h300, 16'd2) || k !== EXP_KEEP || l !== EXP_LAST) begin
      failures++; $display("FAIL t6_after ok=%b wait=%0d got=%h exp=%h", ok, wf, d,
                           exp_pkt(80'hC, 64'h300, 16'd2));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_wrap();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
